// File: rtl/nibble_serializer_pkg.sv
// rtl/nibble_serializer_pkg.sv - shared types and line levels for the nibble serializer
package serializer_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;
    localparam logic TX_STOP  = 1'b1;

endpackage

// File: rtl/nibble_serializer_if.sv
// rtl/nibble_serializer_if.sv - parallel word load handshake into the serializer
interface nibble_serializer_if #(parameter int WIDTH = 4);

    logic [WIDTH-1:0] d;
    logic             load_valid;
    logic             load_ready;

    modport master (output d, output load_valid, input load_ready);
    modport slave  (input d, input load_valid, output load_ready);

endinterface

// File: rtl/nibble_serializer_baud_tick.sv
// rtl/nibble_serializer_baud_tick.sv - bit period counter, tick on the last cycle of each bit
module baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Held at zero while disabled so every frame starts on a fresh bit period.
    always_ff @(posedge clock) begin
        if (clear || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - loads a parallel word and shifts it out as a start/data/stop frame
module nibble_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                    clock,
    input  logic                    clear,
    nibble_serializer_if.slave      bus,
    output logic                    tx,
    output logic                    busy,
    output logic                    done
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BCW-1:0]   bit_cnt, bit_cnt_n;
    logic             tx_n;
    logic             tick;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock  (clock),
        .clear  (clear),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= TX_IDLE;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        done      = 1'b0;
        tx_n      = TX_IDLE;

        case (state)
            IDLE: begin
                if (bus.load_valid) begin
                    state_n = START;
                    shreg_n = bus.d;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from the next-state view so it lines up with the state register.
        case (state_n)
            START:   tx_n = TX_START;
            DATA:    tx_n = shreg_n[0];
            STOP:    tx_n = TX_STOP;
            default: tx_n = TX_IDLE;
        endcase
    end

    assign bus.load_ready = (state == IDLE);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_nibble_serializer.sv
// tb/tb_nibble_serializer.sv - directed and random frame checks against a frame-level model
module tb_nibble_serializer;

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic tx2, busy2, done2;
    logic tx1, busy1, done1;
    int   checks   = 0;
    int   failures = 0;

    nibble_serializer_if #(.WIDTH(4)) bus2 ();
    nibble_serializer_if #(.WIDTH(4)) bus1 ();

    nibble_serializer #(.WIDTH(4), .CLKS_PER_BIT(2)) dut2 (
        .clock (clock),
        .clear (clear),
        .bus   (bus2),
        .tx    (tx2),
        .busy  (busy2),
        .done  (done2)
    );

    nibble_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
        .clock (clock),
        .clear (clear),
        .bus   (bus1),
        .tx    (tx1),
        .busy  (busy1),
        .done  (done1)
    );

    always #5 clock = ~clock;

    function automatic logic txo(int sel);
        return (sel == 1) ? tx1 : tx2;
    endfunction

    function automatic logic bsy(int sel);
        return (sel == 1) ? busy1 : busy2;
    endfunction

    function automatic logic dn(int sel);
        return (sel == 1) ? done1 : done2;
    endfunction

    function automatic logic rdy(int sel);
        return (sel == 1) ? bus1.load_ready : bus2.load_ready;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [3:0] dv);
        if (sel == 1) begin
            bus1.load_valid = v;
            bus1.d          = dv;
        end else begin
            bus2.load_valid = v;
            bus2.d          = dv;
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The expected line level in cycle k after the accept is simply bit k/cpb of {stop, word, start}.
    task automatic send_frame(input int sel, input int cpb, input logic [3:0] word,
                              input bit hold, input logic [3:0] next_d, input bit inject);
        logic [5:0] frame;
        logic [3:0] rebuilt;
        int         nbits;
        frame   = {1'b1, word, 1'b0};
        rebuilt = 4'h0;
        nbits   = 6 * cpb;
        @(negedge clock);
        check1("idle_ready", rdy(sel), 1'b1);
        check1("idle_tx", txo(sel), 1'b1);
        check1("idle_busy", bsy(sel), 1'b0);
        set_in(sel, 1'b1, word);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clock);
            if (k == 0) set_in(sel, hold, next_d);
            if (inject && k == 2 * cpb + 1) set_in(sel, 1'b1, 4'hF);
            if (inject && k == 4 * cpb) set_in(sel, 1'b0, 4'hF);
            check1("frame_tx", txo(sel), frame[k / cpb]);
            check1("frame_busy", bsy(sel), 1'b1);
            check1("frame_ready", rdy(sel), 1'b0);
            check1("frame_done", dn(sel), k == nbits - 1);
            if (k / cpb >= 1 && k / cpb <= 4 && k % cpb == cpb / 2)
                rebuilt[k / cpb - 1] = txo(sel);
        end
        check4("rebuilt_word", rebuilt, word);
    endtask

    initial begin
        logic [3:0] w;
        set_in(1, 1'b1, 4'hA);
        set_in(2, 1'b1, 4'h5);

        // Reset held two cycles with load_valid high.
        repeat (2) begin
            @(negedge clock);
            for (int s = 1; s <= 2; s++) begin
                check1("rst_tx", txo(s), 1'b1);
                check1("rst_busy", bsy(s), 1'b0);
                check1("rst_ready", rdy(s), 1'b1);
                check1("rst_done", dn(s), 1'b0);
            end
        end
        clear = 1'b0;
        set_in(1, 1'b0, 4'h0);
        set_in(2, 1'b0, 4'h0);

        // Basic frame 1010 at two clocks per bit.
        send_frame(2, 2, 4'hA, 1'b0, 4'h7, 1'b0);

        // Load ignored mid-frame.
        send_frame(2, 2, 4'h3, 1'b0, 4'h0, 1'b1);

        // Back-to-back with load_valid held high.
        send_frame(2, 2, 4'h3, 1'b1, 4'hC, 1'b0);
        send_frame(2, 2, 4'hC, 1'b0, 4'h0, 1'b0);

        // Clear during data bit 2, then a clean frame.
        @(negedge clock);
        set_in(2, 1'b1, 4'h6);
        @(negedge clock);
        set_in(2, 1'b0, 4'h9);
        repeat (6) @(negedge clock);
        check1("pre_clear_busy", busy2, 1'b1);
        check1("pre_clear_tx", tx2, 1'b1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check1("clr_tx", tx2, 1'b1);
        check1("clr_busy", busy2, 1'b0);
        check1("clr_ready", bus2.load_ready, 1'b1);
        check1("clr_done", done2, 1'b0);
        repeat (12) begin
            @(negedge clock);
            check1("abandon_done", done2, 1'b0);
            check1("abandon_tx", tx2, 1'b1);
        end
        send_frame(2, 2, 4'h5, 1'b0, 4'h0, 1'b0);

        // One clock per bit.
        send_frame(1, 1, 4'h9, 1'b0, 4'h2, 1'b0);

        // Random words on both instances.
        for (int i = 0; i < 8; i++) begin
            w = 4'($urandom_range(0, 15));
            send_frame((i % 2) + 1, (i % 2 == 0) ? 1 : 2, w, 1'b0, 4'($urandom_range(0, 15)),
                       bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
